safe_entry_ctrl: RTL
====================

# safe_entry_ctrl

Upstream entry stage of the digital safe. Debounces the two front-panel push-buttons and latches the registered password from CH7..CH4 and the attempt from CH3..CH0. It presents both as stable registered words to the combinational compare/display stage. It also consumes that stage's `match` result to track open state, count failed attempts, and enforce a timed lockout.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 16: consecutive stable samples required to accept a button level change.
- `MAX_TRIES`, 3: consecutive failed attempts that trigger lockout (range 1..3).
- `LOCK_CYCLES`, 1000: lockout duration in clock cycles.

Ports:
- `clk`, in, 1: the single clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `btn_store_n`, in, 1: raw "register password" button, active-low, asynchronous to `clk`.
- `btn_try_n`, in, 1: raw "try password" button, active-low, asynchronous to `clk`.
- `sw_new`, in, 4: password switches CH7..CH4.
- `sw_try`, in, 4: attempt switches CH3..CH0.
- `match`, in, 1: equality result from the compare stage, computed combinationally from `stored_pw`/`try_pw`.
- `stored_pw`, out, 4: latched registered password.
- `try_pw`, out, 4: latched attempt.
- `try_valid`, out, 1: `try_pw` holds an attempt evaluated against the current `stored_pw`; downstream gates its LEDs and display on this.
- `opened`, out, 1: safe is open.
- `locked`, out, 1: lockout is active.
- `fail_cnt`, out, 2: consecutive failed attempts.

## Operation
- Each button uses a 2-FF synchronizer, then a debounce counter.
  - The debounced level changes only after `DEBOUNCE_CYCLES` consecutive samples differing from it.
  - A debounced press (released→pressed) produces a one-cycle pulse: `store_p` or `try_p`.
- FSM states: EMPTY, ARMED, CHECK, OPEN, LOCKED.
- **EMPTY**
  - `store_p`: `stored_pw<=sw_new`, go to ARMED.
  - `try_p`: ignored.
- **ARMED**
  - `try_p`: `try_pw<=sw_try`, `try_valid<=1`, go to CHECK.
  - `store_p`: ignored. The password changes only while OPEN.
- **CHECK** (exactly one cycle; `match` is sampled here):
  - `match=1`: go to OPEN, `fail_cnt<=0`.
  - `match=0` and `fail_cnt+1==MAX_TRIES`: go to LOCKED, load the lock counter with `LOCK_CYCLES-1`.
  - `match=0` otherwise: `fail_cnt<=fail_cnt+1`, go to ARMED.
  - Button pulses arriving during CHECK are dropped.
- **OPEN**
  - `opened=1`.
  - `store_p`: `stored_pw<=sw_new`, `try_valid<=0`, go to ARMED.
  - `try_p`: relatch `try_pw`, go to CHECK.
  - Simultaneous `store_p` and `try_p`: store wins.
- **LOCKED**
  - `locked=1`; all pulses ignored.
  - The counter decrements every cycle. In the cycle it reads 0: go to ARMED, `fail_cnt<=0`, `try_valid<=0`.
- `stored_pw` and `try_pw` change only on the latch events above and hold otherwise.

## Timing
- Reset values:
  - `stored_pw=0`, `try_pw=0`, `try_valid=0`, `opened=0`, `locked=0`, `fail_cnt=0`.
  - FSM in EMPTY; lock counter 0.
  - Debounced levels = released; debounce counters 0.
- Reset mid-operation discards the stored password and any lockout.
  - A button held through reset yields one pulse `DEBOUNCE_CYCLES+2` cycles after reset deassertion.
- Raw press edge to pulse: 2 synchronizer cycles + `DEBOUNCE_CYCLES`.
- Pulse to latched output: 1 cycle.
- `try_p` to `opened`/`fail_cnt`/`locked` update: 2 cycles (latch, then CHECK).
- LOCKED lasts exactly `LOCK_CYCLES` cycles.
- `fail_cnt` never exceeds `MAX_TRIES-1` outside LOCKED.

## Configuration
- `SAFE_LOCKOUT_EN` defined:
  - LOCKED state and lock counter present; behaviour as above.
- `SAFE_LOCKOUT_EN` undefined:
  - No LOCKED state; `locked` tied 0.
  - A failed CHECK always returns to ARMED; `fail_cnt` saturates at 3.
  - `LOCK_CYCLES` and `MAX_TRIES` are unused.

## Structure
- Shared package `safe_pkg`:
  - `PW_W=4`.
  - FSM state enum `safe_state_t` (EMPTY, ARMED, CHECK, OPEN, LOCKED).
  - `FAIL_W=2`.
- Sub-module `btn_debounce` (synchronizer + counter + edge pulse, parameter `DEBOUNCE_CYCLES`), instantiated once per button.

## Test plan
Settings: `DEBOUNCE_CYCLES=4`, `MAX_TRIES=3`, `LOCK_CYCLES=20`, `SAFE_LOCKOUT_EN` defined unless noted.
- **Store then correct try:** after reset, `sw_new=4'hA`, press store; `sw_try=4'hA`, press try with `match=1`.
  - Expect `stored_pw=A`, `try_pw=A`, `try_valid=1`.
  - Expect `opened=1` two cycles after `try_p`, `fail_cnt=0`.
- **Bounce filtering:** `btn_try_n` toggles every 2 cycles for 12 cycles, then held low for 10 cycles.
  - Expect exactly one `try_p`, at hold start + 6 cycles.
- **Lockout:** three tries with `match=0`.
  - Expect `fail_cnt` 1, 2, then `locked=1` for exactly 20 cycles; presses during lockout are ignored.
  - Then `locked=0`, `fail_cnt=0`, `try_valid=0`, state ARMED.
- **Password change:** in OPEN, `sw_new=4'h3`, press store.
  - Expect `stored_pw=3`, `try_valid=0`, `opened=0`.
  - A store press in ARMED leaves `stored_pw` unchanged.
- **Simultaneous pulses and reset:** `store_p` and `try_p` in the same cycle in OPEN.
  - Expect store to win (ARMED, `try_pw` unchanged).
  - Assert `rst` during CHECK: all outputs return to 0 next cycle.
- **Build without `SAFE_LOCKOUT_EN`:** five tries with `match=0`.
  - Expect `fail_cnt` 1, 2, 3, 3, 3 and `locked` always 0.

Source files
------------

// File: rtl/safe_pkg.sv
// safe_pkg: shared widths and FSM state encoding for the safe entry stage
package safe_pkg;
  localparam int PW_W = 4;
  localparam int FAIL_W = 2;
  typedef enum logic [2:0] {EMPTY, ARMED, CHECK, OPEN, LOCKED} safe_state_t;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer, stable-sample debounce counter and one-cycle press pulse for an active-low button
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_btn_n,
  output logic o_pulse
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_lvl, r_pulse;
  logic w_diff, w_done;
  assign w_diff = ~r_sync[1] != r_lvl;
  assign w_done = w_diff && r_cnt == LAST;
  assign o_pulse = r_pulse;
  always_ff @(posedge clk)
    if (rst) begin
      r_sync <= 2'b11;
      r_cnt <= '0;
      r_lvl <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync <= {r_sync[0], i_btn_n};
      r_cnt <= (w_diff && !w_done) ? r_cnt + 1'b1 : '0;
      r_lvl <= w_done ? ~r_lvl : r_lvl;
      r_pulse <= w_done && !r_lvl;
    end
endmodule

// File: rtl/safe_entry_ctrl.sv
// safe_entry_ctrl: debounced entry, password/attempt latching and attempt FSM; timed lockout built only with SAFE_LOCKOUT_EN
module safe_entry_ctrl
  import safe_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int MAX_TRIES = 3,
  parameter int LOCK_CYCLES = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_store_n,
  input  logic              btn_try_n,
  input  logic [PW_W-1:0]   sw_new,
  input  logic [PW_W-1:0]   sw_try,
  input  logic              match,
  output logic [PW_W-1:0]   stored_pw,
  output logic [PW_W-1:0]   try_pw,
  output logic              try_valid,
  output logic              opened,
  output logic              locked,
  output logic [FAIL_W-1:0] fail_cnt
);
  if (MAX_TRIES < 1 || MAX_TRIES > 3 || LOCK_CYCLES < 1) begin : g_bad_cfg
    $error("safe_entry_ctrl: MAX_TRIES must be 1..3 and LOCK_CYCLES at least 1");
  end
  localparam logic [FAIL_W-1:0] FAIL_MAX = '1;
  safe_state_t r_state, w_nxt_state;
  logic [PW_W-1:0] r_stored, r_try, w_nxt_stored, w_nxt_try;
  logic [FAIL_W-1:0] r_fail, w_nxt_fail;
  logic r_valid, w_nxt_valid;
  logic w_store_p, w_try_p;
`ifdef SAFE_LOCKOUT_EN
  localparam int LW = LOCK_CYCLES > 1 ? $clog2(LOCK_CYCLES) : 1;
  localparam logic [LW-1:0] LOCK_LOAD = LW'(LOCK_CYCLES - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST = FAIL_W'(MAX_TRIES - 1);
  logic [LW-1:0] r_lock, w_nxt_lock;
`endif
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_store (
    .clk(clk), .rst(rst), .i_btn_n(btn_store_n), .o_pulse(w_store_p)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_try (
    .clk(clk), .rst(rst), .i_btn_n(btn_try_n), .o_pulse(w_try_p)
  );
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_stored = r_stored;
    w_nxt_try = r_try;
    w_nxt_valid = r_valid;
    w_nxt_fail = r_fail;
`ifdef SAFE_LOCKOUT_EN
    w_nxt_lock = r_lock;
`endif
    case (r_state)
      EMPTY: if (w_store_p) begin
        w_nxt_stored = sw_new;
        w_nxt_state = ARMED;
      end
      ARMED: if (w_try_p) begin
        w_nxt_try = sw_try;
        w_nxt_valid = 1'b1;
        w_nxt_state = CHECK;
      end
      CHECK: if (match) begin
        w_nxt_fail = '0;
        w_nxt_state = OPEN;
`ifdef SAFE_LOCKOUT_EN
      end else if (r_fail == FAIL_LAST) begin
        w_nxt_lock = LOCK_LOAD;
        w_nxt_state = LOCKED;
      end else begin
        w_nxt_fail = r_fail + 1'b1;
        w_nxt_state = ARMED;
      end
`else
      end else begin
        w_nxt_fail = r_fail == FAIL_MAX ? r_fail : r_fail + 1'b1;
        w_nxt_state = ARMED;
      end
`endif
      OPEN: if (w_store_p) begin
        w_nxt_stored = sw_new;
        w_nxt_valid = 1'b0;
        w_nxt_state = ARMED;
      end else if (w_try_p) begin
        w_nxt_try = sw_try;
        w_nxt_state = CHECK;
      end
`ifdef SAFE_LOCKOUT_EN
      LOCKED: if (r_lock == '0) begin
        w_nxt_fail = '0;
        w_nxt_valid = 1'b0;
        w_nxt_state = ARMED;
      end else begin
        w_nxt_lock = r_lock - 1'b1;
      end
`endif
      default: w_nxt_state = EMPTY;
    endcase
  end
  always_ff @(posedge clk)
    if (rst) begin
      r_state <= EMPTY;
      r_stored <= '0;
      r_try <= '0;
      r_valid <= 1'b0;
      r_fail <= '0;
`ifdef SAFE_LOCKOUT_EN
      r_lock <= '0;
`endif
    end else begin
      r_state <= w_nxt_state;
      r_stored <= w_nxt_stored;
      r_try <= w_nxt_try;
      r_valid <= w_nxt_valid;
      r_fail <= w_nxt_fail;
`ifdef SAFE_LOCKOUT_EN
      r_lock <= w_nxt_lock;
`endif
    end
  assign stored_pw = r_stored;
  assign try_pw = r_try;
  assign try_valid = r_valid;
  assign fail_cnt = r_fail;
  assign opened = r_state == OPEN;
`ifdef SAFE_LOCKOUT_EN
  assign locked = r_state == LOCKED;
`else
  assign locked = 1'b0;
`endif
endmodule
